// File: rtl/ro_heater_sched.sv
// Ring-oscillator heater job scheduler: queues heating jobs and plays each one out as evenly
// spaced heater start pulses. Statistics counters are built only when RO_SCHED_STATS_EN is defined.
//
// state | meaning
// IDLE  | no job running, waiting for the FIFO to become non-empty
// LOAD  | pop FIFO head, latch heater data/len/on_num and job counters
// PULSE | heater_start high for one cycle
// SPACE | heater_start low for period-1 cycles
// DONE  | job_done pulse, chain straight into the next queued job
// FLUSH | heater_rst high for 2 cycles after abort, FIFO emptied
module ro_heater_sched #(
  parameter int MAX_BIT_SIZE   = 256,
  parameter int MAX_RO_HEATERS = 5,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic [MAX_BIT_SIZE-1:0]         cmd_data_i,
  input  logic [$clog2(MAX_BIT_SIZE)-1:0] cmd_len_i,
  input  logic [31:0]                     cmd_on_num_i,
  input  logic [15:0]                     cmd_period_i,
  input  logic [15:0]                     cmd_repeat_i,
  input  logic                            abort_i,
  output logic                            heater_rst_o,
  output logic                            heater_start_o,
  output logic [MAX_BIT_SIZE-1:0]         heater_data_o,
  output logic [$clog2(MAX_BIT_SIZE)-1:0] heater_data_len_o,
  output logic [31:0]                     heater_on_num_o,
  output logic                            busy_o,
  output logic                            job_done_o,
  output logic                            err_bad_cmd_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
  output logic [31:0]                     stat_active_cycles_o,
  output logic [31:0]                     stat_jobs_done_o
);

  localparam int LW  = $clog2(MAX_BIT_SIZE);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int PCW = LW + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PULSE,
    S_SPACE,
    S_DONE,
    S_FLUSH
  } state_t;

  typedef struct packed {
    logic [MAX_BIT_SIZE-1:0] data;
    logic [LW-1:0]           len;
    logic [31:0]             on_num;
    logic [15:0]             period;
    logic [15:0]             rpt;
  } job_t;

  state_t              state_q, state_d;
  logic [15:0]         per_cnt_q, per_cnt_d;
  logic [PCW-1:0]      pulses_q, pulses_d;
  logic [15:0]         passes_q, passes_d;
  logic [15:0]         period_q, period_d;
  logic                flush_cnt_q, flush_cnt_d;
  logic [1:0]          init_q;
  logic                err_q;
  logic                load_en;

  job_t                mem_q [FIFO_DEPTH];
  job_t                cmd_job;
  job_t                head;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;

  logic [MAX_BIT_SIZE-1:0] hdata_q;
  logic [LW-1:0]           hlen_q;
  logic [31:0]             hon_q;

  logic fifo_full, fifo_empty, pop, push, hs, bad_cmd, st_flush;

  assign cmd_job    = {cmd_data_i, cmd_len_i, cmd_on_num_i, cmd_period_i, cmd_repeat_i};
  assign head       = mem_q[rd_ptr_q];
  assign st_flush   = (state_q == S_FLUSH);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = (state_q == S_LOAD) && !abort_i;

  assign bad_cmd = (cmd_len_i == '0) || (cmd_period_i < 16'd2) ||
                   (cmd_on_num_i == 32'd0) || (cmd_on_num_i > 32'(MAX_RO_HEATERS));

  // A pop in LOAD frees a slot in the same cycle, so a full FIFO can still take a push then.
  assign cmd_ready_o = rst_n_i && !st_flush && (!fifo_full || pop);
  assign hs          = cmd_valid_i && cmd_ready_o;
  assign push        = hs && !bad_cmd && !abort_i;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= cmd_job;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (abort_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    pulses_d    = pulses_q;
    passes_d    = passes_q;
    period_d    = period_q;
    flush_cnt_d = flush_cnt_q;
    load_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        load_en  = 1'b1;
        pulses_d = PCW'(head.len) + PCW'({head.len, 1'b0});
        passes_d = (head.rpt == 16'd0) ? 16'd1 : head.rpt;
        period_d = head.period;
        state_d  = S_PULSE;
      end
      S_PULSE: begin
        per_cnt_d = period_q - 16'd2;
        state_d   = S_SPACE;
        if (pulses_q == PCW'(1)) begin
          // Last pulse of the final pass: no trailing gap before DONE.
          if (passes_q <= 16'd1) begin
            state_d = S_DONE;
          end else begin
            pulses_d = PCW'(hlen_q) + PCW'({hlen_q, 1'b0});
            passes_d = passes_q - 16'd1;
          end
        end else begin
          pulses_d = pulses_q - PCW'(1);
        end
      end
      S_SPACE: begin
        if (per_cnt_q == 16'd0) state_d = S_PULSE;
        else                    per_cnt_d = per_cnt_q - 16'd1;
      end
      S_DONE: begin
        state_d = fifo_empty ? S_IDLE : S_LOAD;
      end
      S_FLUSH: begin
        if (flush_cnt_q == 1'b0) state_d = S_IDLE;
        else                     flush_cnt_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d     = S_FLUSH;
      flush_cnt_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      per_cnt_q   <= '0;
      pulses_q    <= '0;
      passes_q    <= '0;
      period_q    <= '0;
      flush_cnt_q <= 1'b0;
      init_q      <= 2'd2;
      err_q       <= 1'b0;
      hdata_q     <= '0;
      hlen_q      <= '0;
      hon_q       <= '0;
    end else begin
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      pulses_q    <= pulses_d;
      passes_q    <= passes_d;
      period_q    <= period_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= hs && bad_cmd;
      if (init_q != 2'd0) init_q <= init_q - 2'd1;
      if (load_en) begin
        hdata_q <= head.data;
        hlen_q  <= head.len;
        hon_q   <= head.on_num;
      end
    end
  end

  assign heater_rst_o      = (init_q != 2'd0) || st_flush;
  assign heater_start_o    = (state_q == S_PULSE);
  assign heater_data_o     = hdata_q;
  assign heater_data_len_o = hlen_q;
  assign heater_on_num_o   = hon_q;
  assign busy_o            = (state_q != S_IDLE) || !fifo_empty;
  assign job_done_o        = (state_q == S_DONE);
  assign err_bad_cmd_o     = err_q;
  assign fifo_count_o      = count_q;

`ifdef RO_SCHED_STATS_EN
  logic [31:0] act_cnt_q, jobs_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      act_cnt_q  <= '0;
      jobs_cnt_q <= '0;
    end else begin
      if ((state_q != S_IDLE) && (act_cnt_q != 32'hFFFF_FFFF)) act_cnt_q <= act_cnt_q + 32'd1;
      if ((state_q == S_DONE) && (jobs_cnt_q != 32'hFFFF_FFFF)) jobs_cnt_q <= jobs_cnt_q + 32'd1;
    end
  end

  assign stat_active_cycles_o = act_cnt_q;
  assign stat_jobs_done_o     = jobs_cnt_q;
`else
  assign stat_active_cycles_o = 32'd0;
  assign stat_jobs_done_o     = 32'd0;
`endif

endmodule
